// File: rtl/dmem_responder.sv
// dmem_responder
//   Multi-cycle word-wide data memory serving the MEM-stage load/store port.
//   A held request is captured, LATENCY wait cycles elapse, then the access
//   completes and a single-cycle ack returns read data and an error flag.
//   Ports:
//     clk, reset           clock (rising edge), async active-high reset
//     mem_req              request valid, held by the initiator until mem_ack
//     mem_we               1 = store word, 0 = load word
//     mem_addr[31:0]       byte address (must be word aligned)
//     mem_wdata[31:0]      store data
//     mem_ack              one-cycle response strobe
//     mem_rdata[31:0]      load data, valid while mem_ack=1 (0 otherwise)
//     mem_err              misaligned/out-of-range request, valid with mem_ack
//     busy                 request in progress (WAIT or RESP)
module dmem_responder #(
  parameter int unsigned DEPTH   = 256,
  parameter int unsigned LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic        mem_ack,
  output logic [31:0] mem_rdata,
  output logic        mem_err,
  output logic        busy
);

  localparam int unsigned AW         = $clog2(DEPTH);
  localparam logic [32:0] ADDR_LIMIT = 33'(DEPTH) * 33'd4;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [3:0]  r_cnt;
  logic [3:0]  w_cnt_nxt;
  logic        r_we;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_mem [DEPTH];

  logic          w_capture;
  logic          w_err;
  logic          w_wr_en;
  logic          w_ack_nxt;
  logic          w_err_nxt;
  logic          w_busy_nxt;
  logic [31:0]   w_rdata_nxt;
  logic [AW-1:0] w_idx;

  assign w_idx = r_addr[AW+1:2];
  assign w_err = (r_addr[1:0] != 2'b00) || ({1'b0, r_addr} >= ADDR_LIMIT);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_capture   = 1'b0;
    w_wr_en     = 1'b0;
    w_ack_nxt   = 1'b0;
    w_err_nxt   = 1'b0;
    w_rdata_nxt = '0;
    case (r_state)
      S_IDLE: begin
        if (mem_req) begin
          w_capture   = 1'b1;
          w_cnt_nxt   = 4'(LATENCY);
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (r_cnt != 4'd0) begin
          w_cnt_nxt = r_cnt - 4'd1;
        end else begin
          // Access happens on the edge entering RESP so the ack cycle
          // already presents the result.
          w_state_nxt = S_RESP;
          w_ack_nxt   = 1'b1;
          w_err_nxt   = w_err;
          w_wr_en     = r_we && !w_err;
          if (!r_we && !w_err) begin
            w_rdata_nxt = r_mem[w_idx];
          end
        end
      end
      S_RESP: begin
        // A request still held during the ack cycle is taken on the edge
        // that ends RESP, giving LATENCY+2 cycles between acks.
        if (mem_req) begin
          w_capture   = 1'b1;
          w_cnt_nxt   = 4'(LATENCY);
          w_state_nxt = S_WAIT;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    w_busy_nxt = (w_state_nxt != S_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      mem_ack   <= 1'b0;
      mem_err   <= 1'b0;
      mem_rdata <= '0;
      busy      <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      mem_ack   <= w_ack_nxt;
      mem_err   <= w_err_nxt;
      mem_rdata <= w_rdata_nxt;
      busy      <= w_busy_nxt;
      if (w_capture) begin
        r_we    <= mem_we;
        r_addr  <= mem_addr;
        r_wdata <= mem_wdata;
      end
    end
  end

  // Storage is intentionally not reset; an aborted store never reaches here
  // because reset forces the FSM out of WAIT.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[w_idx] <= r_wdata;
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

  localparam int L     = 2;
  localparam int DEPTH = 256;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mem_req = 1'b0;
  logic        mem_we = 1'b0;
  logic [31:0] mem_addr = '0;
  logic [31:0] mem_wdata = '0;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        mem_err;
  logic        busy;

  logic        req0 = 1'b0;
  logic        we0 = 1'b0;
  logic [31:0] addr0 = '0;
  logic [31:0] wdata0 = '0;
  logic        ack0;
  logic [31:0] rdata0;
  logic        err0;
  logic        busy0;

  int checks = 0;
  int errors = 0;

  logic [31:0] model [DEPTH];

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH(DEPTH), .LATENCY(L)) dut (
    .clk(clk), .reset(reset), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .mem_err(mem_err), .busy(busy)
  );

  dmem_responder #(.DEPTH(DEPTH), .LATENCY(0)) dut0 (
    .clk(clk), .reset(reset), .mem_req(req0), .mem_we(we0),
    .mem_addr(addr0), .mem_wdata(wdata0), .mem_ack(ack0),
    .mem_rdata(rdata0), .mem_err(err0), .busy(busy0)
  );

  // One complete transaction on the LATENCY=L instance, with exact-cycle
  // expectations taken from the model array and the address rules.
  task automatic run_req(input logic we, input logic [31:0] addr, input logic [31:0] wd);
    logic        exp_err;
    logic [31:0] exp_rd;
    logic [7:0]  idx;
    idx     = addr[9:2];
    exp_err = (addr[1:0] != 2'b00) || (addr >= 32'(DEPTH * 4));
    exp_rd  = (exp_err || we) ? 32'h0 : model[idx];
    @(negedge clk);
    mem_req = 1'b1; mem_we = we; mem_addr = addr; mem_wdata = wd;
    @(posedge clk); #1;
    // Garbage on the bus after acceptance must be ignored.
    mem_req = 1'b0; mem_we = 1'($urandom); mem_addr = $urandom; mem_wdata = $urandom;
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL busy_after_accept addr=%h got %b exp 1", addr, busy); end
    for (int n = 1; n <= L + 1; n++) begin
      @(posedge clk); #1;
      if (n < L + 1) begin
        checks++;
        if (mem_ack !== 1'b0 || busy !== 1'b1) begin
          errors++; $display("FAIL wait_cycle%0d addr=%h ack=%b busy=%b exp ack=0 busy=1", n, addr, mem_ack, busy);
        end
      end else begin
        checks++;
        if (mem_ack !== 1'b1 || mem_err !== exp_err || mem_rdata !== exp_rd || busy !== 1'b1) begin
          errors++;
          $display("FAIL ack_cycle addr=%h we=%b got ack=%b err=%b rdata=%h busy=%b exp ack=1 err=%b rdata=%h busy=1",
                   addr, we, mem_ack, mem_err, mem_rdata, busy, exp_err, exp_rd);
        end
      end
    end
    @(posedge clk); #1;
    checks++;
    if (mem_ack !== 1'b0 || mem_err !== 1'b0 || mem_rdata !== 32'h0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL after_ack addr=%h got ack=%b err=%b rdata=%h busy=%b exp all 0", addr, mem_ack, mem_err, mem_rdata, busy);
    end
    if (we && !exp_err) model[idx] = wd;
  endtask

  task automatic init_fill();
    for (int i = 0; i < DEPTH; i++) run_req(1'b1, 32'(i * 4), $urandom);
  endtask

  task automatic test_reset();
    run_req(1'b1, 32'h14, 32'hA5A5_1234);
    @(negedge clk);
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h14;
    @(posedge clk); #1;
    mem_req = 1'b0;
    repeat (L + 1) @(posedge clk);
    #1;
    checks++;
    if (mem_ack !== 1'b1 || mem_rdata !== 32'hA5A5_1234) begin
      errors++; $display("FAIL reset_precond ack=%b rdata=%h exp ack=1 rdata=a5a51234", mem_ack, mem_rdata);
    end
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++;
    if (mem_ack !== 1'b0 || mem_err !== 1'b0 || busy !== 1'b0 || mem_rdata !== 32'h0) begin
      errors++;
      $display("FAIL async_reset ack=%b err=%b busy=%b rdata=%h exp all 0", mem_ack, mem_err, busy, mem_rdata);
    end
    @(negedge clk);
    reset = 1'b0;
    // Contents survive reset.
    run_req(1'b0, 32'h14, 32'h0);
  endtask

  task automatic test_load();
    run_req(1'b1, 32'h14, 32'hDEAD_BEEF);
    run_req(1'b0, 32'h14, 32'h0);
  endtask

  task automatic test_store_load();
    run_req(1'b1, 32'h20, 32'h1234_5678);
    run_req(1'b0, 32'h20, 32'h0);
    checks++;
    if (model[8] !== 32'h1234_5678) begin errors++; $display("FAIL model_word8 got %h exp 12345678", model[8]); end
  endtask

  task automatic test_errors();
    run_req(1'b0, 32'h13, 32'h0);
    run_req(1'b1, 32'h400, 32'hCAFE_F00D);
    run_req(1'b0, 32'h3FE, 32'h0);
    run_req(1'b1, 32'hFFFF_FFFC, 32'h1111_2222);
    run_req(1'b1, 32'h3FC, 32'h7777_8888);
    run_req(1'b0, 32'h3FC, 32'h0);
    for (int i = 0; i < DEPTH; i++) run_req(1'b0, 32'(i * 4), 32'h0);
  endtask

  task automatic test_held();
    int acks [2];
    int na;
    logic [31:0] d;
    d  = $urandom;
    na = 0;
    @(negedge clk);
    mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h40; mem_wdata = d;
    for (int e = 1; e <= 30 && na < 2; e++) begin
      @(posedge clk); #1;
      if (mem_ack === 1'b1) begin acks[na] = e; na++; end
      if (na == 2) mem_req = 1'b0;
    end
    mem_req = 1'b0;
    model[16] = d;
    checks++;
    if (na != 2 || acks[0] != L + 2 || acks[1] - acks[0] != L + 2) begin
      errors++; $display("FAIL held_spacing acks=%0d first=%0d second=%0d exp first=%0d gap=%0d", na, acks[0], acks[1], L + 2, L + 2);
    end
    @(posedge clk); #1;
    checks++;
    if (mem_ack !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL held_release ack=%b busy=%b exp 0 0", mem_ack, busy); end
    run_req(1'b0, 32'h40, 32'h0);

    na = 0;
    @(negedge clk);
    req0 = 1'b1; we0 = 1'b1; addr0 = 32'h8; wdata0 = 32'h55;
    for (int e = 1; e <= 30 && na < 2; e++) begin
      @(posedge clk); #1;
      if (ack0 === 1'b1) begin acks[na] = e; na++; end
      if (na == 2) req0 = 1'b0;
    end
    req0 = 1'b0;
    checks++;
    if (na != 2 || acks[0] != 2 || acks[1] - acks[0] != 2) begin
      errors++; $display("FAIL held_lat0 acks=%0d first=%0d second=%0d exp first=2 gap=2", na, acks[0], acks[1]);
    end
    @(posedge clk); #1;
    checks++;
    if (ack0 !== 1'b0 || busy0 !== 1'b0 || rdata0 !== 32'h0) begin
      errors++; $display("FAIL lat0_release ack=%b busy=%b rdata=%h exp 0 0 0", ack0, busy0, rdata0);
    end
  endtask

  task automatic test_abort();
    int na;
    run_req(1'b1, 32'h8, 32'h0BAD_F00D);
    @(negedge clk);
    mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h8; mem_wdata = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    mem_req = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || mem_ack !== 1'b0) begin errors++; $display("FAIL abort_reset busy=%b ack=%b exp 0 0", busy, mem_ack); end
    @(negedge clk);
    reset = 1'b0;
    na = 0;
    for (int e = 0; e < 8; e++) begin
      @(posedge clk); #1;
      if (mem_ack !== 1'b0 || busy !== 1'b0) na++;
    end
    checks++;
    if (na != 0) begin errors++; $display("FAIL abort_no_ack active_cycles=%0d exp 0", na); end
    run_req(1'b0, 32'h8, 32'h0);
  endtask

  task automatic test_random();
    logic [31:0] a;
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 9))
        0:       a = 32'($urandom_range(0, 1023));
        1:       a = $urandom | 32'h400;
        default: a = 32'($urandom_range(0, 15) * 4);
      endcase
      run_req(1'($urandom), a, $urandom);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    checks++;
    if (mem_ack !== 1'b0 || busy !== 1'b0 || mem_rdata !== 32'h0 || mem_err !== 1'b0) begin
      errors++; $display("FAIL power_on_reset ack=%b busy=%b rdata=%h err=%b exp all 0", mem_ack, busy, mem_rdata, mem_err);
    end
    reset = 1'b0;
    init_fill();
    test_reset();
    test_load();
    test_store_load();
    test_errors();
    test_held();
    test_abort();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
